// File: rtl/cksum_pkg.sv
// +------------------------------------------------------------------+
// | cksum_pkg: shared state encoding and widths for cksum_insert      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package cksum_pkg;
  localparam int c_ACC_W = 32;
  localparam int c_CK_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SUM   = 3'd2,
    S_FOLD  = 3'd3,
    S_WRITE = 3'd4
  } state_t;
endpackage

`default_nettype wire

// File: rtl/cksum_insert_fold.sv
// +------------------------------------------------------------------+
// | ones_fold16: 32-to-16 one's-complement end-around-carry fold      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module ones_fold16
  import cksum_pkg::*;
(
  input  logic [c_ACC_W-1:0] i_acc,
  output logic [c_CK_W-1:0]  o_sum
);
  logic [c_CK_W:0] w_s1;

  assign w_s1  = {1'b0, i_acc[c_ACC_W-1:c_CK_W]} + {1'b0, i_acc[c_CK_W-1:0]};
  // When the carry is set the low half is at most 0xFFFE, so adding it back cannot overflow.
  assign o_sum = w_s1[c_CK_W-1:0] + {{(c_CK_W-1){1'b0}}, w_s1[c_CK_W]};
endmodule

`default_nettype wire

// File: rtl/cksum_insert.sv
// +------------------------------------------------------------------+
// | cksum_insert: zeroes a checksum slot, sums the covered header     |
// | range one 16-bit word per cycle and writes the Internet checksum. |
// | Optional verify mode: CKSUM_VERIFY_EN.                            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module cksum_insert
  import cksum_pkg::*;
#(
  parameter int HDR_MAX_LEN = 64,
  parameter int ADDR_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
`ifdef CKSUM_VERIFY_EN
  input  logic                        verify_i,
  output logic                        ok_o,
`endif
  input  logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_i,
  input  logic [ADDR_W-1:0]           field_start_i,
  input  logic [ADDR_W-1:0]           field_len_i,
  input  logic [ADDR_W-1:0]           cksum_off_i,
  output logic                        busy_o,
  output logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_o,
  output logic [c_CK_W-1:0]           cksum_val_o,
  output logic                        done_o,
  output logic                        error_o
);
  localparam int c_IDX_W = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;

  state_t                        r_state, w_state_nxt;
  logic [HDR_MAX_LEN-1:0][7:0]   r_buf;
  logic [ADDR_W-1:0]             r_start, r_len, r_off, r_addr, r_rem;
  logic [c_ACC_W-1:0]            r_acc;
  logic [c_CK_W-1:0]             r_ck;
  logic                          r_done, r_err;
  logic [ADDR_W:0]               w_end, w_slot_end;
  logic                          w_bad, w_last, w_verify;
  logic [c_IDX_W-1:0]            w_idx0, w_idx1, w_off0, w_off1;
  logic [7:0]                    w_hi, w_lo;
  logic [c_CK_W-1:0]             w_fold, w_ck;

  assign w_end      = {1'b0, r_start} + {1'b0, r_len};
  assign w_slot_end = {1'b0, r_off} + (ADDR_W+1)'(2);
  assign w_bad      = (w_end > (ADDR_W+1)'(HDR_MAX_LEN)) ||
                      (w_slot_end > (ADDR_W+1)'(HDR_MAX_LEN));

  assign w_idx0 = r_addr[c_IDX_W-1:0];
  assign w_idx1 = r_addr[c_IDX_W-1:0] + c_IDX_W'(1);
  assign w_off0 = r_off[c_IDX_W-1:0];
  assign w_off1 = r_off[c_IDX_W-1:0] + c_IDX_W'(1);
  assign w_hi   = r_buf[w_idx0];
  // A single trailing byte is padded with zero in the low position.
  assign w_lo   = (r_rem == ADDR_W'(1)) ? 8'h00 : r_buf[w_idx1];
  assign w_last = (r_rem <= ADDR_W'(2));

  ones_fold16 u_fold (
    .i_acc (r_acc),
    .o_sum (w_fold)
  );
  assign w_ck = ~w_fold;

`ifdef CKSUM_VERIFY_EN
  logic r_verify, r_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_verify <= 1'b0;
      r_ok     <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_verify <= verify_i;
      r_ok     <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_ok     <= r_verify && (w_ck == '0);
    end
  end

  assign w_verify = r_verify;
  assign ok_o     = r_ok;
`else
  assign w_verify = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_bad)                  w_state_nxt = S_IDLE;
        else if (r_len == '0)       w_state_nxt = S_FOLD;
        else                        w_state_nxt = S_SUM;
      end
      S_SUM:   if (w_last) w_state_nxt = S_FOLD;
      S_FOLD:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_off   <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
      r_ck    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_buf   <= pkt_hdr_i;
          r_start <= field_start_i;
          r_len   <= field_len_i;
          r_off   <= cksum_off_i;
          r_acc   <= '0;
        end
        S_LOAD: begin
          if (w_bad) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end else begin
            if (!w_verify) begin
              r_buf[w_off0] <= 8'h00;
              r_buf[w_off1] <= 8'h00;
            end
            r_addr <= r_start;
            r_rem  <= r_len;
          end
        end
        S_SUM: begin
          r_acc  <= r_acc + {{(c_ACC_W-c_CK_W){1'b0}}, w_hi, w_lo};
          r_addr <= r_addr + ADDR_W'(2);
          r_rem  <= r_rem - ADDR_W'(2);
        end
        S_FOLD: r_acc <= {{(c_ACC_W-c_CK_W){1'b0}}, w_fold};
        S_WRITE: begin
          r_ck   <= w_ck;
          r_done <= 1'b1;
          if (!w_verify) begin
            r_buf[w_off0] <= w_ck[15:8];
            r_buf[w_off1] <= w_ck[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign pkt_hdr_o   = r_buf;
  assign cksum_val_o = r_ck;
  assign done_o      = r_done;
  assign error_o     = r_err;
endmodule

`default_nettype wire

// File: tb/tb_cksum_insert.sv
// Testbench for cksum_insert: fixed vectors, corner sequences and a
// randomized run against a byte-level Internet checksum model.
`timescale 1ns/1ps
`default_nettype none

module tb_cksum_insert;
  localparam int HDR = 64;
  localparam int AW  = 8;
  localparam logic [7:0] IPV4 [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40,
                                       8'h00, 8'h40, 8'h11, 8'h00, 8'h00, 8'hc0, 8'ha8,
                                       8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

  typedef logic [HDR-1:0][7:0] hdr_t;
  typedef struct {
    hdr_t        hdr;
    int          s;
    int          l;
    int          o;
    logic [15:0] ck;
    int          cyc;
    logic        err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  hdr_t          pkt_hdr_i = '0;
  logic [AW-1:0] field_start_i = '0;
  logic [AW-1:0] field_len_i = '0;
  logic [AW-1:0] cksum_off_i = '0;
  logic          busy_o, done_o, error_o;
  hdr_t          pkt_hdr_o;
  logic [15:0]   cksum_val_o;
`ifdef CKSUM_VERIFY_EN
  logic          verify_i = 1'b0;
  logic          ok_o;
`endif

  int checks = 0;
  int failures = 0;

  cksum_insert #(.HDR_MAX_LEN(HDR), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
`ifdef CKSUM_VERIFY_EN
    .verify_i      (verify_i),
    .ok_o          (ok_o),
`endif
    .pkt_hdr_i     (pkt_hdr_i),
    .field_start_i (field_start_i),
    .field_len_i   (field_len_i),
    .cksum_off_i   (cksum_off_i),
    .busy_o        (busy_o),
    .pkt_hdr_o     (pkt_hdr_o),
    .cksum_val_o   (cksum_val_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_hdr(input string name, input hdr_t act, input hdr_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic hdr_t rnd_hdr();
    hdr_t h;
    for (int i = 0; i < HDR; i++) h[i] = 8'($urandom);
    return h;
  endfunction

  function automatic hdr_t ipv4_hdr(input logic preset_ff);
    hdr_t h = '0;
    for (int i = 0; i < 20; i++) h[i] = IPV4[i];
    if (preset_ff) begin
      h[10] = 8'hFF;
      h[11] = 8'hFF;
    end
    return h;
  endfunction

  // Reference: zero slot, sum big-endian words with zero pad, fold until no carry, invert.
  function automatic void model(input hdr_t h, input int s, input int l, input int o,
                                output hdr_t eh, output logic [15:0] ck,
                                output logic bad, output int cyc);
    logic [7:0]  b [HDR];
    int unsigned sum;
    logic [7:0]  lo;
    eh  = h;
    ck  = 16'h0;
    bad = (s + l > HDR) || (o + 2 > HDR);
    cyc = 2;
    if (bad) return;
    for (int i = 0; i < HDR; i++) b[i] = h[i];
    b[o]     = 8'h00;
    b[o + 1] = 8'h00;
    sum = 0;
    for (int i = 0; i < l; i += 2) begin
      lo  = (i + 1 < l) ? b[s + i + 1] : 8'h00;
      sum = sum + 32'({b[s + i], lo});
    end
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    eh[o]     = ck[15:8];
    eh[o + 1] = ck[7:0];
    cyc = (l == 0) ? 4 : (l + 1) / 2 + 4;
  endfunction

  task automatic issue(input hdr_t h, input int s, input int l, input int o);
    pkt_hdr_i     = h;
    field_start_i = AW'(s);
    field_len_i   = AW'(l);
    cksum_off_i   = AW'(o);
    start_i       = 1'b1;
  endtask

  // Called just before edge 0 with start_i high; returns at the done cycle (negedge).
  task automatic wait_done(output int cyc);
    cyc = -1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_i       = 1'b0;
        pkt_hdr_i     = rnd_hdr();
        field_start_i = AW'($urandom);
        field_len_i   = AW'($urandom);
        cksum_off_i   = AW'($urandom);
        chk("busy_after_start", 32'(busy_o), 32'd1);
      end
      if (done_o) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done_o within 100 cycles got none expected pulse");
    end else begin
      chk("busy_in_done", 32'(busy_o), 32'd0);
    end
  endtask

  task automatic run_model(input string tag, input hdr_t h, input int s, input int l, input int o);
    hdr_t        eh;
    logic [15:0] eck;
    logic        bad;
    int          ecyc, cyc;
    model(h, s, l, o, eh, eck, bad, ecyc);
    @(negedge clk);
    issue(h, s, l, o);
    wait_done(cyc);
    chk({tag, "_cyc"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_err"}, 32'(error_o), 32'(bad));
    if (!bad) chk({tag, "_ck"}, 32'(cksum_val_o), 32'(eck));
    chk_hdr({tag, "_hdr"}, pkt_hdr_o, eh);
  endtask

  vec_t tbl [7];

  initial begin
    int          cyc, seen;
    hdr_t        h, exp_h;
    int          s, l, o;

    tbl[0] = '{ipv4_hdr(1'b0), 0, 20, 10, 16'hB861, 14, 1'b0};
    tbl[1] = '{ipv4_hdr(1'b1), 0, 20, 10, 16'hB861, 14, 1'b0};
    h = '0; h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h03;
    tbl[2] = '{h, 0, 3, 4, 16'hFBFD, 6, 1'b0};
    tbl[3] = '{ipv4_hdr(1'b0), 0, 0, 10, 16'hFFFF, 4, 1'b0};
    tbl[4] = '{ipv4_hdr(1'b0), 60, 8, 10, 16'h0000, 2, 1'b1};
    tbl[5] = '{ipv4_hdr(1'b0), 0, 20, 63, 16'h0000, 2, 1'b1};
    tbl[6] = '{hdr_t'('0), 0, 64, 62, 16'hFFFF, 36, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_ck", 32'(cksum_val_o), 32'd0);
    chk_hdr("rst_hdr", pkt_hdr_o, '0);
`ifdef CKSUM_VERIFY_EN
    chk("rst_ok", 32'(ok_o), 32'd0);
`endif
    rst = 1'b1;

    // Fixed vectors
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      issue(tbl[i].hdr, tbl[i].s, tbl[i].l, tbl[i].o);
      wait_done(cyc);
      exp_h = tbl[i].hdr;
      if (!tbl[i].err) begin
        exp_h[tbl[i].o]     = tbl[i].ck[15:8];
        exp_h[tbl[i].o + 1] = tbl[i].ck[7:0];
        chk($sformatf("vec%0d_ck", i), 32'(cksum_val_o), 32'(tbl[i].ck));
      end
      chk($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("vec%0d_err", i), 32'(error_o), 32'(tbl[i].err));
      chk_hdr($sformatf("vec%0d_hdr", i), pkt_hdr_o, exp_h);
    end

    // Back-to-back: new start presented in the done cycle
    @(negedge clk);
    issue(ipv4_hdr(1'b0), 0, 20, 10);
    wait_done(cyc);
    chk("b2b_first_cyc", 32'(cyc), 32'd14);
    h = '0; h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h03;
    issue(h, 0, 3, 4);
    wait_done(cyc);
    chk("b2b_second_cyc", 32'(cyc), 32'd6);
    chk("b2b_second_ck", 32'(cksum_val_o), 32'h0000FBFD);

    // Reset asserted while summing
    @(negedge clk);
    issue(ipv4_hdr(1'b0), 0, 20, 10);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_err", 32'(error_o), 32'd0);
    chk("midrst_ck", 32'(cksum_val_o), 32'd0);
    chk_hdr("midrst_hdr", pkt_hdr_o, '0);
    rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // Randomized descriptors against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        s = $urandom_range(0, 70);
        l = $urandom_range(0, 70);
        o = $urandom_range(0, 70);
      end else begin
        s = $urandom_range(0, HDR - 1);
        l = $urandom_range(0, HDR - s);
        o = $urandom_range(0, HDR - 2);
      end
      run_model($sformatf("rnd%0d", n), rnd_hdr(), s, l, o);
    end

`ifdef CKSUM_VERIFY_EN
    h = ipv4_hdr(1'b0);
    h[10] = 8'hB8;
    h[11] = 8'h61;
    @(negedge clk);
    issue(h, 0, 20, 10);
    verify_i = 1'b1;
    wait_done(cyc);
    chk("ver_good_ok", 32'(ok_o), 32'd1);
    chk("ver_good_ck", 32'(cksum_val_o), 32'd0);
    chk_hdr("ver_good_hdr", pkt_hdr_o, h);
    h[0] = 8'h46;
    @(negedge clk);
    issue(h, 0, 20, 10);
    verify_i = 1'b1;
    wait_done(cyc);
    chk("ver_bad_ok", 32'(ok_o), 32'd0);
    chk_hdr("ver_bad_hdr", pkt_hdr_o, h);
    verify_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
